// File: rtl/counter_sequencer.sv
// Run-control sequencer around an n-bit modulo-k up-counter.
// Start/stop/pause commands, one-shot or periodic wrap, registered pulses.
module counter_sequencer #(
  parameter int n          = 4,
  parameter int DEF_PERIOD = 15
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Pause,
  input  logic         Mode,
  input  logic [n-1:0] Period,
  input  logic         Tick_en,
  output logic [n-1:0] Q,
  output logic         Rollover,
  output logic         Done,
  output logic         Error,
  output logic         Busy,
  output logic [1:0]   State
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_e;

  state_e       state_q, state_d;
  logic [n-1:0] q_q, q_d;
  logic [n-1:0] period_q, period_d;
  logic         mode_q, mode_d;
  logic         roll_q, roll_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;
  logic [n-1:0] last_c;
  logic         start_ok, step, wrap;

  // Period >= 2 means some bit above bit 0 is set
  assign start_ok = Start && (Period[n-1:1] != '0);
  assign last_c   = period_q - n'(1);
  assign step     = (state_q == RUN) && !Stop && !Start
                 && !Pause && Tick_en;
  assign wrap     = step && (q_q == last_c);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      period_q <= n'(DEF_PERIOD);
      mode_q   <= 1'b0;
      roll_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      roll_q   <= roll_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    period_d = period_q;
    mode_d   = mode_q;
    if (Stop) begin
      state_d = IDLE;
      q_d     = '0;
    end else if (start_ok) begin
      state_d  = RUN;
      q_d      = '0;
      period_d = Period;
      mode_d   = Mode;
    end else if (Start) begin
      // rejected start: DONE still lasts a single cycle
      if (state_q == DONE) state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (Pause) begin
            state_d = PAUSED;
          end else if (wrap) begin
            q_d = '0;
            if (!mode_q) state_d = DONE;
          end else if (step) begin
            q_d = q_q + n'(1);
          end
        end
        PAUSED: if (!Pause) state_d = RUN;
        DONE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    roll_d = wrap;
    done_d = wrap && !mode_q;
    err_d  = Start && !Stop && !start_ok;
    busy_d = (state_d == RUN) || (state_d == PAUSED);
  end

  assign Q        = q_q;
  assign Rollover = roll_q;
  assign Done     = done_q;
  assign Error    = err_q;
  assign Busy     = busy_q;
  assign State    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random
// commands, each cycle compared to a behavioural model.
module tb_counter_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, pause, mode, tick;
  logic [N-1:0] period;
  logic [N-1:0] q;
  logic         roll, done, err, busy;
  logic [1:0]   st;

  int n_chk  = 0;
  int n_fail = 0;

  int m_st, m_q, m_k, m_mode;
  bit m_roll, m_done, m_err;

  always #5 clk = ~clk;

  counter_sequencer #(.n(N), .DEF_PERIOD(15)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Start   (start),
    .Stop    (stop),
    .Pause   (pause),
    .Mode    (mode),
    .Period  (period),
    .Tick_en (tick),
    .Q       (q),
    .Rollover(roll),
    .Done    (done),
    .Error   (err),
    .Busy    (busy),
    .State   (st)
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model: states 0 idle, 1 run, 2 paused, 3 done
  task automatic model_step();
    m_roll = 0;
    m_done = 0;
    m_err  = 0;
    if (!rst_n) begin
      m_st = 0; m_q = 0; m_k = 15; m_mode = 0;
      return;
    end
    if (stop) begin
      m_st = 0; m_q = 0;
      return;
    end
    if (start) begin
      if (int'(period) >= 2) begin
        m_k = period; m_mode = mode; m_q = 0; m_st = 1;
      end else begin
        m_err = 1;
        if (m_st == 3) m_st = 0;
      end
      return;
    end
    case (m_st)
      1: begin
        if (pause) m_st = 2;
        else if (tick) begin
          m_q = (m_q + 1) % m_k;
          if (m_q == 0) begin
            m_roll = 1;
            if (m_mode == 0) begin
              m_done = 1; m_st = 3;
            end
          end
        end
      end
      2: if (!pause) m_st = 1;
      3: m_st = 0;
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("Q", q, m_q);
    check("State", st, m_st);
    check("Rollover", roll, m_roll);
    check("Done", done, m_done);
    check("Error", err, m_err);
    check("Busy", busy, (m_st == 1 || m_st == 2));
  endtask

  task automatic go(input int p, input bit md);
    start = 1; period = p[N-1:0]; mode = md;
    cycle();
    start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; stop = 0; pause = 0;
    mode = 0; tick = 0; period = '0;
    cycle();
    cycle();
    check("rst_q", q, 0);
    check("rst_state", st, 0);
    check("rst_busy", busy, 0);
    rst_n = 1;

    // periodic, k=5
    tick = 1;
    go(5, 1);
    check("t1_start_q", q, 0);
    check("t1_start_st", st, 1);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("t1_q", q, (i + 1) % 5);
      check("t1_roll", roll, ((i + 1) % 5) == 0);
      check("t1_done", done, 0);
    end

    // one-shot, k=3
    go(3, 0);
    cycle(); cycle();
    check("t2_q2", q, 2);
    cycle();
    check("t2_wrap_q", q, 0);
    check("t2_wrap_st", st, 3);
    check("t2_wrap_done", done, 1);
    check("t2_wrap_roll", roll, 1);
    check("t2_wrap_busy", busy, 0);
    cycle();
    check("t2_idle_st", st, 0);
    check("t2_idle_done", done, 0);

    // pause at Q=5, k=6
    go(6, 1);
    for (int i = 0; i < 5; i++) cycle();
    check("t3_q5", q, 5);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_pq", q, 5);
      check("t3_pst", st, 2);
    end
    pause = 0;
    cycle();
    check("t3_resume_q", q, 5);
    check("t3_resume_st", st, 1);
    cycle();
    check("t3_wrap_q", q, 0);
    check("t3_wrap_roll", roll, 1);

    // rejected starts from IDLE
    stop = 1; cycle(); stop = 0;
    go(1, 1);
    check("t4_err1", err, 1);
    check("t4_st1", st, 0);
    go(0, 0);
    check("t4_err0", err, 1);
    check("t4_q0", q, 0);
    cycle();
    check("t4_err_clr", err, 0);

    // start+stop together, then restart mid-run
    go(8, 1);
    for (int i = 0; i < 3; i++) cycle();
    check("t5_q3", q, 3);
    start = 1; stop = 1; period = 4'd9;
    cycle();
    start = 0; stop = 0;
    check("t5_ss_st", st, 0);
    check("t5_ss_q", q, 0);
    check("t5_ss_err", err, 0);
    go(8, 1);
    cycle(); cycle();
    go(4, 1);
    check("t5_rs_q", q, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("t5_new_mod_q", q, 0);
    check("t5_new_mod_roll", roll, 1);

    // reset mid-run at Q=7, then tick gaps
    go(15, 1);
    for (int i = 0; i < 7; i++) cycle();
    check("t6_q7", q, 7);
    rst_n = 0; cycle(); rst_n = 1;
    check("t6_rst_q", q, 0);
    check("t6_rst_st", st, 0);
    check("t6_rst_pulse", {roll, done, err}, 0);
    go(3, 1);
    for (int i = 0; i < 20; i++) begin
      tick = (i % 3) == 1;
      cycle();
    end

    // random phase
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom % 300) != 0;
      start  = ($urandom % 12) == 0;
      stop   = ($urandom % 30) == 0;
      if (($urandom % 10) == 0) pause = ~pause;
      tick   = ($urandom % 4) != 0;
      period = N'($urandom);
      mode   = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run-control sequencer wrapped around an n-bit modulo-k up-counter. It accepts start/stop/pause commands, latches a period and a mode on each start, and steps the count only on enabled ticks. In periodic mode it wraps continuously. In one-shot mode it wraps once and then reports completion. Downstream timing logic uses it as the programmable event/timebase source.

Parameters:
n, 4, counter and period width in bits
DEF_PERIOD, 15, period value held in the internal period register after reset (read-back only)

Ports:
Clock     input   1   system clock; all state changes on rising edge
Reset_n   input   1   synchronous, active-low reset
Start     input   1   start/restart request, sampled each cycle
Stop      input   1   abort request, sampled each cycle
Pause     input   1   level; high holds the count while running
Mode      input   1   0 = one-shot, 1 = periodic; sampled only on an accepted Start
Period    input   n   modulus k (count runs 0..k-1); sampled only on an accepted Start
Tick_en   input   1   count-step enable (prescaler strobe)
Q         output  n   current count
Rollover  output  1   one-cycle pulse, high in the cycle Q has just wrapped to 0
Done      output  1   one-cycle pulse on one-shot completion
Error     output  1   one-cycle pulse when a Start is rejected
Busy      output  1   high in RUN or PAUSED
State     output  2   IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset:
  - Reset_n=0 at a rising Clock edge: State=IDLE, Q=0, Rollover=0, Done=0, Error=0, Busy=0, period register=DEF_PERIOD, mode register=0.
  - Reset has priority over every other input.
  - Reset mid-run aborts immediately; no Done or Rollover is issued.
- Command priority, highest first: Reset > Stop > Start > Pause > Tick_en.
- Start acceptance:
  - Start is accepted in any state when Period >= 2.
  - On acceptance: latch Period and Mode, set Q=0, go to RUN next cycle.
  - No count step occurs on the accepting edge.
  - Start in RUN or PAUSED is a restart: new Period and Mode are latched and Q returns to 0.
- Start rejection:
  - Start with Period of 0 or 1 is rejected: Error pulses for 1 cycle; State, Q and the latched registers are unchanged.
- IDLE: Q holds 0; Tick_en and Pause are ignored.
- RUN, with Pause=0 and Tick_en=1:
  - If Q < k-1: Q <= Q+1.
  - If Q == k-1: Q <= 0 and Rollover <= 1 on the same edge.
  - On that wrap in one-shot mode: State <= DONE and Done <= 1 on the same edge.
  - On that wrap in periodic mode: State stays RUN.
- RUN with Tick_en=0: Q holds and Rollover=0.
- Pause:
  - RUN with Pause=1: go to PAUSED; no step on that edge, even if Tick_en=1 and Q == k-1.
  - PAUSED with Pause=0: return to RUN; no step on that edge.
  - Q holds throughout PAUSED.
- Stop:
  - In RUN or PAUSED: go to IDLE and set Q=0 on the same edge; no Rollover or Done is issued.
  - In IDLE or DONE: no effect.
  - Stop and Start in the same cycle: Stop wins and Start is dropped (no Error).
- DONE:
  - Lasts exactly 1 cycle with Q=0, then goes to IDLE automatically unless Start is accepted in that cycle (then RUN).
- Pulse outputs: Rollover, Done and Error are 0 in every cycle not listed above.
- Derived outputs: Busy = (State==RUN || State==PAUSED), registered with State.
- Width and stability:
  - Comparisons are unsigned n-bit. Q never exceeds k-1; Period = 2^n - 1 is legal.
  - Changes to Period or Mode while not starting have no effect.

Test Plan:
1. Reset, then Start with Period=5, Mode=1 and Tick_en held high -> Q sequence 0,1,2,3,4,0,1...; Rollover high exactly in the cycles where Q=0 after a wrap (every 5 cycles); Busy=1; Done never asserts.
2. Start with Period=3, Mode=0 and Tick_en high -> Q 0,1,2,0; Rollover and Done both pulse on the wrap edge; State goes 01 -> 11 for one cycle -> 00; Busy drops with DONE.
3. Periodic run with Period=6, Pause asserted at Q=5 for 3 cycles while Tick_en=1 -> Q holds 5 for 4 cycles (pause entry, 2 paused cycles, resume edge), then 0 with a Rollover pulse; State shows 10 while paused.
4. Start with Period=1, then with Period=0 -> Error pulses once each; State stays 00; Q=0.
5. Running at Q=3: assert Start and Stop together -> IDLE, Q=0, no Error. Next, restart mid-run with Period=4 -> Q=0 and the new modulus is observed.
6. Assert Reset_n=0 for one edge at Q=7 in RUN with Period=15 -> Q=0, State=00, all pulse outputs 0; Tick_en=0 gaps in a run freeze Q with no spurious Rollover.
